// File: rtl/oflow_buffer_write_pkg.sv
// Shared types and constants for the frame-buffer write controller.
// grp_base is the first buffer address of a quad within the frame layout.
package oflow_buffer_write_pkg;

    localparam int unsigned PE_NUM = 24;
    localparam int unsigned QUAD   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WRITE,
        DONE
    } state_t;

    function automatic int unsigned calc_grp_base(input int unsigned row,
                                                  input int unsigned pe,
                                                  input int unsigned pe_num);
        return row * pe_num + pe * QUAD;
    endfunction

endpackage

// File: rtl/oflow_quad_serializer.sv
// Holds one captured bbox group and emits it one word per cycle
// as registered write-enable/address/data.
module oflow_quad_serializer
    import oflow_buffer_write_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [2:0]               len,
    input  logic [ADDR_W-1:0]        base,
    input  logic [QUAD*DATA_W-1:0]   data,
    output logic                     we,
    output logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        wdata,
    output logic                     last
);

    logic [QUAD-1:0][DATA_W-1:0] data_q;
    logic [2:0]                  len_q;
    logic [2:0]                  cur_k;
    logic [2:0]                  nxt_k;
    logic [ADDR_W-1:0]           base_q;

    assign nxt_k = cur_k + 3'd1;
    assign last  = we && (cur_k == len_q - 3'd1);

    // NOTE: the capture register is a handful of flops, not a RAM, so it is
    // reset along with everything else; a real memory array would not be.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            len_q  <= '0;
            base_q <= '0;
            cur_k  <= '0;
            we     <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
        end else if (load) begin
            // Word 0 goes out on the cycle right after the capture edge.
            data_q <= data;
            len_q  <= len;
            base_q <= base;
            cur_k  <= 3'd0;
            we     <= 1'b1;
            addr   <= base;
            wdata  <= data[DATA_W-1:0];
        end else if (we && !last) begin
            cur_k  <= nxt_k;
            addr   <= base_q + ADDR_W'(nxt_k);
            wdata  <= data_q[nxt_k[1:0]];
        end else begin
            we     <= 1'b0;
        end
    end

endmodule

// File: rtl/oflow_buffer_fsm_write.sv
// Frame-buffer write controller: accepts quad groups from the core sequencer,
// serialises them into the buffer and signals when the whole frame is stored.
module oflow_buffer_fsm_write
    import oflow_buffer_write_pkg::*;
#(
    parameter int unsigned PE_NUM = oflow_buffer_write_pkg::PE_NUM,
    parameter int          DATA_W = 64,
    parameter int          ADDR_W = 10,
    parameter int          NUM_W  = 10,
    parameter int          ROW_W  = 4,
    parameter int          PE_W   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_W-1:0]         num_of_bbox_in_frame,
    input  logic                     start_write,
    input  logic                     ready_from_core,
    input  logic [1:0]               remainder,
    input  logic [ROW_W-1:0]         row_sel,
    input  logic [PE_W-1:0]          pe_sel,
    input  logic [4*DATA_W-1:0]      quad_data,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     busy,
    output logic                     done_write_buffer,
    output logic                     overflow_err
);

    state_t             state_q, state_d;
    logic [NUM_W-1:0]   frame_total;
    logic [NUM_W-1:0]   written_cnt;
    logic [NUM_W:0]     cnt_after;
    logic               frame_end;
    logic               start_accept;
    logic               load;
    logic               drop;
    logic               room;
    logic               suppress;
    logic               ser_we;
    logic               ser_last;
    logic [2:0]         grp_len;
    logic [ADDR_W-1:0]  grp_base;

    assign grp_base = ADDR_W'(calc_grp_base(32'(row_sel), 32'(pe_sel), PE_NUM));
    assign grp_len  = (remainder == 2'd0) ? 3'd4 : {1'b0, remainder};

    // Words past the latched frame length never reach the buffer.
    assign room      = written_cnt < frame_total;
    assign mem_we    = ser_we && room;
    assign suppress  = ser_we && !room;
    assign cnt_after = {1'b0, written_cnt} + (NUM_W+1)'(mem_we);
    assign frame_end = cnt_after >= {1'b0, frame_total};

    assign start_accept      = (state_q == IDLE) && start_write;
    assign busy              = (state_q != IDLE);
    assign done_write_buffer = (state_q == DONE);

    oflow_quad_serializer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_serializer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .len   (grp_len),
        .base  (grp_base),
        .data  (quad_data),
        .we    (ser_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .last  (ser_last)
    );

    // NOTE: every always_comb output gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_write)
                    state_d = (num_of_bbox_in_frame == '0) ? DONE : ARMED;
            end
            ARMED: begin
                if (ready_from_core) begin
                    load    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (ser_last) begin
                    if (frame_end) begin
                        state_d = DONE;
                        drop    = ready_from_core;
                    end else if (ready_from_core) begin
                        load    = 1'b1;
                    end else begin
                        state_d = ARMED;
                    end
                end else begin
                    drop = ready_from_core;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_total  <= '0;
            written_cnt  <= '0;
            overflow_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_accept) begin
                frame_total  <= num_of_bbox_in_frame;
                written_cnt  <= '0;
                overflow_err <= 1'b0;
            end else begin
                if (mem_we)
                    written_cnt <= written_cnt + NUM_W'(1);
                if (drop || suppress)
                    overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oflow_buffer_fsm_write.sv
// Self-checking bench for oflow_buffer_fsm_write: table of quad pulses with
// hand-derived base addresses, a write scoreboard, and corner-case sequences.
module tb_oflow_buffer_fsm_write;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 10;
    localparam int NUM_W  = 10;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_W-1:0]    num_of_bbox_in_frame;
    logic                start_write;
    logic                ready_from_core;
    logic [1:0]          remainder;
    logic [3:0]          row_sel;
    logic [2:0]          pe_sel;
    logic [4*DATA_W-1:0] quad_data;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                busy;
    logic                done_write_buffer;
    logic                overflow_err;

    oflow_buffer_fsm_write dut (
        .clk                  (clk),
        .reset                (reset),
        .num_of_bbox_in_frame (num_of_bbox_in_frame),
        .start_write          (start_write),
        .ready_from_core      (ready_from_core),
        .remainder            (remainder),
        .row_sel              (row_sel),
        .pe_sel               (pe_sel),
        .quad_data            (quad_data),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .busy                 (busy),
        .done_write_buffer    (done_write_buffer),
        .overflow_err         (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] row;
        logic [2:0] pe;
        logic [1:0] rem;
        int         exp_base;
        int         exp_len;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    vec_t tbl [9];
    wr_t  sb [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_writes, n_done, done_cyc;
    int model_cnt, model_total;
    bit model_ovf;
    int last_pulse_cyc, last_len;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every buffer write must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                n_writes++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h with empty scoreboard", mem_addr, mem_wdata);
                end else begin
                    wr_t w;
                    w = sb.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(w.addr));
                    check("wr_data", mem_wdata, w.data);
                end
            end
            if (done_write_buffer) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int num);
        n_writes    = 0;
        n_done      = 0;
        done_cyc    = -1;
        model_cnt   = 0;
        model_total = num;
        model_ovf   = 1'b0;
        num_of_bbox_in_frame = NUM_W'(num);
        start_write = 1'b1;
        last_pulse_cyc = cyc;
        last_len    = 0;
        tick();
        start_write = 1'b0;
    endtask

    // Drive one quad pulse for table entry idx, then hold idle so the
    // total time spent is gap cycles.
    task automatic do_pulse(input int idx, input bit push, input int gap);
        ready_from_core = 1'b1;
        row_sel   = tbl[idx].row;
        pe_sel    = tbl[idx].pe;
        remainder = tbl[idx].rem;
        for (int k = 0; k < 4; k++)
            quad_data[k*DATA_W +: DATA_W] = {$urandom, $urandom};
        if (push) begin
            for (int k = 0; k < tbl[idx].exp_len; k++) begin
                if (model_cnt < model_total) begin
                    wr_t w;
                    w.addr = ADDR_W'(tbl[idx].exp_base + k);
                    w.data = quad_data[k*DATA_W +: DATA_W];
                    sb.push_back(w);
                    model_cnt++;
                end else begin
                    model_ovf = 1'b1;
                end
            end
            last_pulse_cyc = cyc;
            last_len       = tbl[idx].exp_len;
        end
        tick();
        ready_from_core = 1'b0;
        quad_data = '0;
        repeat (gap - 1) tick();
    endtask

    task automatic finish_frame(input string name, input bit exp_done);
        repeat (6) tick();
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_writes"}, 64'(n_writes), 64'(model_cnt));
        check({name, "_done_count"}, 64'(n_done), exp_done ? 64'd1 : 64'd0);
        if (exp_done)
            check({name, "_done_cycle"}, 64'(done_cyc), 64'(last_pulse_cyc + last_len + 1));
        check({name, "_overflow"}, 64'(overflow_err), 64'(model_ovf));
        check({name, "_busy"}, 64'(busy), exp_done ? 64'd0 : 64'd1);
        sb.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{4'd0, 3'd0, 2'd0, 0,   4};
        tbl[1] = '{4'd0, 3'd1, 2'd0, 4,   4};
        tbl[2] = '{4'd0, 3'd2, 2'd0, 8,   4};
        tbl[3] = '{4'd0, 3'd3, 2'd0, 12,  4};
        tbl[4] = '{4'd0, 3'd4, 2'd0, 16,  4};
        tbl[5] = '{4'd0, 3'd5, 2'd0, 20,  4};
        tbl[6] = '{4'd1, 3'd0, 2'd3, 24,  3};
        tbl[7] = '{4'd3, 3'd2, 2'd2, 80,  2};
        tbl[8] = '{4'd5, 3'd7, 2'd1, 148, 1};

        reset = 1'b1;
        num_of_bbox_in_frame = '0;
        start_write = 1'b0;
        ready_from_core = 1'b0;
        remainder = '0;
        row_sel = '0;
        pe_sel = '0;
        quad_data = '0;
        n_writes = 0;
        n_done = 0;
        done_cyc = -1;
        repeat (2) tick();
        check("rst_mem_we",   64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_busy",     64'(busy), 64'd0);
        check("rst_done",     64'(done_write_buffer), 64'd0);
        check("rst_overflow", 64'(overflow_err), 64'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Two full quads, back-to-back at a 4-cycle cadence.
        start_frame(8);
        for (int i = 0; i < 2; i++) do_pulse(i, 1'b1, tbl[i].exp_len);
        finish_frame("num8", 1'b1);

        // Full row of six quads plus a 3-word remainder group on row 1.
        start_frame(27);
        for (int i = 0; i < 7; i++) do_pulse(i, 1'b1, tbl[i].exp_len);
        finish_frame("num27", 1'b1);

        // Short groups back-to-back at higher rows/quads.
        start_frame(3);
        for (int i = 7; i < 9; i++) do_pulse(i, 1'b1, tbl[i].exp_len);
        finish_frame("num3", 1'b1);

        // Second pulse arrives mid-group and must be dropped.
        start_frame(8);
        do_pulse(0, 1'b1, 2);
        do_pulse(1, 1'b0, 4);
        model_ovf = 1'b1;
        finish_frame("drop", 1'b0);
        pulse_reset();
        check("drop_rst_overflow", 64'(overflow_err), 64'd0);
        check("drop_rst_busy", 64'(busy), 64'd0);

        // Empty frame finishes without writing.
        start_frame(0);
        finish_frame("num0", 1'b1);

        // Sequencer sends more words than the frame holds.
        start_frame(5);
        do_pulse(0, 1'b1, 4);
        do_pulse(1, 1'b1, 4);
        finish_frame("mismatch", 1'b1);

        // Reset after the second word of the first group.
        start_frame(8);
        do_pulse(0, 1'b1, 2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_mem_we",   64'(mem_we), 64'd0);
        check("midrst_mem_addr", 64'(mem_addr), 64'd0);
        check("midrst_mem_wdata", mem_wdata, 64'd0);
        check("midrst_busy",     64'(busy), 64'd0);
        check("midrst_done",     64'(done_write_buffer), 64'd0);
        check("midrst_writes",   64'(n_writes), 64'd2);
        sb.delete();
        tick();
        reset = 1'b0;
        n_writes = 0;
        n_done = 0;
        model_total = 0;
        do_pulse(0, 1'b0, 4);
        repeat (4) tick();
        check("norestart_writes", 64'(n_writes), 64'd0);
        check("norestart_done",   64'(n_done), 64'd0);
        check("norestart_busy",   64'(busy), 64'd0);
        check("norestart_ovf",    64'(overflow_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
